// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants and types for the CNN header parser:
//                header byte addresses, error encodings, descriptor field
//                widths and the parser state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DEFAULT_MAX_LAYERS = 10;

    localparam int ADDR_W  = 16;
    localparam int COUNT_W = 8;
    localparam int INDEX_W = 4;
    localparam int FSQ_W   = 16;
    localparam int ACC_W   = 18;

    // Header layout in parameter RAM
    localparam logic [2:0]  HDR_FILTER_SIZE = 3'd0;
    localparam logic [2:0]  HDR_NUM_LAYERS  = 3'd1;
    localparam logic [2:0]  HDR_FOFF_HI     = 3'd2;
    localparam logic [2:0]  HDR_FOFF_LO     = 3'd3;
    localparam logic [2:0]  HDR_DOFF_HI     = 3'd4;
    localparam logic [2:0]  HDR_DOFF_LO     = 3'd5;
    localparam logic [15:0] COUNT_BASE      = 16'd6;

    localparam logic [1:0] ERR_OK             = 2'd0;
    localparam logic [1:0] ERR_BAD_HEADER     = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW       = 2'd2;
    localparam logic [1:0] ERR_DENSE_MISMATCH = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_HDR        = 4'd1,
        S_CHECK      = 4'd2,
        S_CONV_RD    = 4'd3,
        S_CONV_EMIT  = 4'd4,
        S_XCHK       = 4'd5,
        S_DENSE_RD   = 4'd6,
        S_DENSE_EMIT = 4'd7,
        S_FIN        = 4'd8
    } parseState_t;

endpackage
`default_nettype wire

// File: rtl/layer_size_acc.sv
`default_nettype none
// ============================================================================
//  Module      : layer_size_acc
//  Description : Combinational conv-section accumulator step.
//                accOut = accIn + count*(1+fsq); overflow when the sum no
//                longer fits a 16-bit RAM address.
//  Ports       : count (filters in layer), fsq (filterSize^2),
//                accIn (running offset), accOut, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_size_acc
    import cnn_pkg::*;
(
    input  logic [COUNT_W-1:0] count,
    input  logic [FSQ_W-1:0]   fsq,
    input  logic [ACC_W-1:0]   accIn,
    output logic [ACC_W-1:0]   accOut,
    output logic               overflow
);

    // 255 * 65026 still fits 24 bits, so the product never wraps.
    logic [23:0] w_layerSize;
    logic [24:0] w_sum;

    always_comb begin
        w_layerSize = 24'(count) * (24'(fsq) + 24'd1);
        w_sum       = 25'(accIn) + 25'(w_layerSize);
    end

    assign accOut   = w_sum[ACC_W-1:0];
    assign overflow = (w_sum > 25'h0_FFFF);

endmodule
`default_nettype wire

// File: rtl/cnn_header_parser.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_header_parser
//  Description : Reads the CNN model header from parameter RAM and emits one
//                descriptor per conv layer and per dense layer (N-1 of them),
//                cross-checking the dense offset against the computed conv
//                section size.
//  Ports       : clk/RST, start/busy/done/errCode (control),
//                ramAddress/readSignal/ramDataOut (RAM read port),
//                filterSize/numLayers/filterOffset/denseOffset (header regs),
//                descValid/descReady/descDense/descIndex/descCount/descBase
//                (descriptor stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_header_parser
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS  = DEFAULT_MAX_LAYERS,
    parameter int RAM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [1:0]         errCode,
    output logic [ADDR_W-1:0]  ramAddress,
    output logic               readSignal,
    input  logic [7:0]         ramDataOut,
    output logic [7:0]         filterSize,
    output logic [7:0]         numLayers,
    output logic [15:0]        filterOffset,
    output logic [15:0]        denseOffset,
    output logic               descValid,
    input  logic               descReady,
    output logic               descDense,
    output logic [INDEX_W-1:0] descIndex,
    output logic [COUNT_W-1:0] descCount,
    output logic [ADDR_W-1:0]  descBase
);

    localparam int LAT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);
    localparam logic [LAT_W-1:0]   c_ramLat    = LAT_W'(RAM_LATENCY);
    localparam logic [COUNT_W-1:0] c_maxLayers = COUNT_W'(MAX_LAYERS);

    parseState_t        r_state, w_nextState;
    logic [LAT_W-1:0]   r_wait;     // 0 = issue read, c_ramLat = sample data
    logic [2:0]         r_hdrIdx;
    logic [INDEX_W-1:0] r_layer;
    logic [COUNT_W-1:0] r_count;
    logic [FSQ_W-1:0]   r_fsq;
    logic [ACC_W-1:0]   r_acc, w_accNext;
    logic [1:0]         r_err;
    logic [7:0]         r_filterSize, r_numLayers;
    logic [15:0]        r_filterOffset, r_denseOffset;

    logic w_overflow, w_sampleNow, w_issueNow, w_handshake;
    logic w_badHeader, w_lastConv, w_lastDense, w_mismatch;

    layer_size_acc u_layerSizeAcc (
        .count    (r_count),
        .fsq      (r_fsq),
        .accIn    (r_acc),
        .accOut   (w_accNext),
        .overflow (w_overflow)
    );

    assign w_issueNow  = (r_wait == '0);
    assign w_sampleNow = (r_wait == c_ramLat);
    assign descValid   = (r_state == S_CONV_EMIT) || (r_state == S_DENSE_EMIT);
    assign w_handshake = descValid && descReady;
    assign w_badHeader = (r_filterSize == 8'd0) || (r_numLayers == 8'd0) ||
                         (r_numLayers > c_maxLayers);
    assign w_lastConv  = (COUNT_W'(r_layer) + 8'd1) == r_numLayers;
    assign w_lastDense = (COUNT_W'(r_layer) + 8'd2) == r_numLayers;
    assign w_mismatch  = (r_acc[15:0] != r_denseOffset);

    assign busy         = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done         = (r_state == S_FIN);
    assign errCode      = r_err;
    assign filterSize   = r_filterSize;
    assign numLayers    = r_numLayers;
    assign filterOffset = r_filterOffset;
    assign denseOffset  = r_denseOffset;
    assign descDense    = (r_state == S_DENSE_EMIT);
    assign descIndex    = r_layer;
    assign descCount    = r_count;
    // Dense layers all share the section base; per-layer offsets are
    // derived downstream.
    assign descBase     = descDense ? r_denseOffset : r_acc[15:0];

    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        readSignal  = 1'b0;
        ramAddress  = '0;
        case (r_state)
            S_IDLE:       if (start) w_nextState = S_HDR;
            S_HDR: begin
                readSignal = w_issueNow;
                ramAddress = {13'd0, r_hdrIdx};
                if (w_sampleNow && (r_hdrIdx == HDR_DOFF_LO)) w_nextState = S_CHECK;
            end
            S_CHECK:      w_nextState = w_badHeader ? S_FIN : S_CONV_RD;
            S_CONV_RD: begin
                readSignal = w_issueNow;
                ramAddress = COUNT_BASE + 16'(r_layer);
                if (w_sampleNow) w_nextState = S_CONV_EMIT;
            end
            S_CONV_EMIT: begin
                if (w_handshake) begin
                    if (w_overflow)      w_nextState = S_FIN;
                    else if (w_lastConv) w_nextState = S_XCHK;
                    else                 w_nextState = S_CONV_RD;
                end
            end
            S_XCHK: begin
                if (w_mismatch || (r_numLayers == 8'd1)) w_nextState = S_FIN;
                else                                     w_nextState = S_DENSE_RD;
            end
            S_DENSE_RD: begin
                readSignal = w_issueNow;
                ramAddress = COUNT_BASE + 16'(r_numLayers) + 16'(r_layer);
                if (w_sampleNow) w_nextState = S_DENSE_EMIT;
            end
            S_DENSE_EMIT: begin
                if (w_handshake) w_nextState = w_lastDense ? S_FIN : S_DENSE_RD;
            end
            S_FIN:        w_nextState = S_IDLE;
            default:      w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wait         <= '0;
            r_hdrIdx       <= '0;
            r_layer        <= '0;
            r_count        <= '0;
            r_fsq          <= '0;
            r_acc          <= '0;
            r_err          <= ERR_OK;
            r_filterSize   <= '0;
            r_numLayers    <= '0;
            r_filterOffset <= '0;
            r_denseOffset  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err    <= ERR_OK;
                        r_hdrIdx <= '0;
                        r_wait   <= '0;
                    end
                end
                S_HDR: begin
                    if (w_sampleNow) begin
                        r_wait   <= '0;
                        r_hdrIdx <= r_hdrIdx + 3'd1;
                        case (r_hdrIdx)
                            HDR_FILTER_SIZE: r_filterSize         <= ramDataOut;
                            HDR_NUM_LAYERS:  r_numLayers          <= ramDataOut;
                            HDR_FOFF_HI:     r_filterOffset[15:8] <= ramDataOut;
                            HDR_FOFF_LO:     r_filterOffset[7:0]  <= ramDataOut;
                            HDR_DOFF_HI:     r_denseOffset[15:8]  <= ramDataOut;
                            HDR_DOFF_LO:     r_denseOffset[7:0]   <= ramDataOut;
                            default: ;
                        endcase
                    end else begin
                        r_wait <= r_wait + LAT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_badHeader) begin
                        r_err <= ERR_BAD_HEADER;
                    end else begin
                        r_fsq   <= 16'(r_filterSize) * 16'(r_filterSize);
                        r_acc   <= ACC_W'(r_filterOffset);
                        r_layer <= '0;
                        r_wait  <= '0;
                    end
                end
                S_CONV_RD, S_DENSE_RD: begin
                    if (w_sampleNow) begin
                        r_count <= ramDataOut;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + LAT_W'(1);
                    end
                end
                S_CONV_EMIT: begin
                    if (w_handshake) begin
                        if (w_overflow) begin
                            r_err <= ERR_OVERFLOW;
                        end else begin
                            r_acc <= w_accNext;
                            if (!w_lastConv) r_layer <= r_layer + 4'd1;
                        end
                    end
                end
                S_XCHK: begin
                    if (w_mismatch) r_err <= ERR_DENSE_MISMATCH;
                    r_layer <= '0;
                end
                S_DENSE_EMIT: begin
                    if (w_handshake && !w_lastDense) r_layer <= r_layer + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
